// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU datapath.
//
// Contents:
//   op_e          - 2-bit add/subtract opcode (ADD, ADC, SUB, SBB)
//   flags_t       - packed status flags {c, v, z, n}
//   op_invert_b   - 1 when the opcode subtracts, so operand B is inverted
//   op_carry_in   - carry into bit 0 for a given opcode and carry input
package alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_ADC = 2'd1,
    OP_SUB = 2'd2,
    OP_SBB = 2'd3
  } op_e;

  typedef struct packed {
    logic c;
    logic v;
    logic z;
    logic n;
  } flags_t;

  // Subtraction is done as A + ~B + c0, so SUB/SBB invert B.
  function automatic logic op_invert_b(input op_e op);
    return (op == OP_SUB) || (op == OP_SBB);
  endfunction

  // SUB forces the +1 of two's complement; ADC/SBB take the external
  // carry (for SBB a carry of 1 means "no borrow pending").
  function automatic logic op_carry_in(input op_e op, input logic cin);
    logic c0;
    case (op)
      OP_ADD:  c0 = 1'b0;
      OP_SUB:  c0 = 1'b1;
      default: c0 = cin;
    endcase
    return c0;
  endfunction

endpackage : alu_pkg

// File: rtl/add_slice.sv
// add_slice: W-bit combinational ripple slice of the pipelined adder.
//
// Ports:
//   a_i     in  W  operand A slice
//   b_i     in  W  effective operand B slice (already inverted for subtract)
//   cin_i   in  1  carry into bit 0 of the slice
//   sum_o   out W  slice sum
//   cout_o  out 1  carry out of bit W-1
//   cmsb_o  out 1  carry into bit W-1 (used for signed overflow of the top slice)
module add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] sum_o,
  output logic         cout_o,
  output logic         cmsb_o
);

  logic [W:0] full;

  assign full   = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
  assign sum_o  = full[W-1:0];
  assign cout_o = full[W];
  // sum[msb] = a ^ b ^ carry_in[msb], so the carry into the MSB can be
  // recovered from the sum bit without a second adder.
  assign cmsb_o = a_i[W-1] ^ b_i[W-1] ^ sum_o[W-1];

endmodule : add_slice

// File: rtl/pipe_add_sub.sv
// pipe_add_sub: pipelined N-bit add/subtract with carry-in and flags.
//
// The N-bit operation is split into STAGES equal slices of W = N/STAGES
// bits. Stage k (1..STAGES) computes slice k-1 from the contents of
// stage k-1 (stage 0 is the input port) and forwards the untouched
// operand slices, the partial result, the running carry and a running
// zero flag. The final stage also registers the signed-overflow flag.
//
// Handshake (both sides): a beat transfers on a rising edge where
// valid and ready are both 1. The producer holds nothing it has not
// offered; the unit never retracts out_valid until out_ready takes the
// beat, and out_* stay stable while out_valid=1 and out_ready=0.
// in_ready depends only on pipeline occupancy and out_ready, never on
// in_valid.
//
// Ports:
//   clk        in  1  clock, rising edge
//   rst        in  1  asynchronous reset, active-high
//   in_valid   in  1  operand beat offered
//   in_ready   out 1  unit accepts a beat this cycle
//   in_a       in  N  operand A
//   in_b       in  N  operand B
//   in_cin     in  1  carry input (ADC/SBB only)
//   in_op      in  2  0=ADD 1=ADC 2=SUB 3=SBB
//   out_valid  out 1  result beat available
//   out_ready  in  1  consumer takes the beat this cycle
//   out_sum    out N  result
//   out_c      out 1  carry out of bit N-1 (SUB/SBB: 1 = no borrow)
//   out_v      out 1  signed overflow
//   out_z      out 1  out_sum == 0
//   out_n      out 1  out_sum[N-1]
module pipe_add_sub
  import alu_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_a,
  input  logic [N-1:0] in_b,
  input  logic         in_cin,
  input  logic [1:0]   in_op,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_sum,
  output logic         out_c,
  output logic         out_v,
  output logic         out_z,
  output logic         out_n
);

  localparam int W = N / STAGES;

  if ((N % STAGES) != 0) begin : g_bad_cfg
    $error("pipe_add_sub: N must be an exact multiple of STAGES");
  end

  // ---------------------------------------------------------------------
  // Stage registers, index 1..STAGES. Operand slices already consumed are
  // kept at zero so they carry no live state.
  // ---------------------------------------------------------------------
  logic [N-1:0]      a_q [1:STAGES];
  logic [N-1:0]      b_q [1:STAGES];
  logic [N-1:0]      s_q [1:STAGES];
  logic [STAGES:1]   c_q;
  logic [STAGES:1]   z_q;
  logic [STAGES:1]   valid_q;
  logic              v_q;

  // Source of each stage's computation (index g feeds stage g+1).
  logic [N-1:0]      src_a [0:STAGES-1];
  logic [N-1:0]      src_b [0:STAGES-1];
  logic [N-1:0]      src_s [0:STAGES-1];
  logic              src_c [0:STAGES-1];
  logic              src_z [0:STAGES-1];
  logic              src_v [0:STAGES-1];

  // Next-state values for each stage, computed from its source.
  logic [N-1:0]      nx_a [0:STAGES-1];
  logic [N-1:0]      nx_b [0:STAGES-1];
  logic [N-1:0]      nx_s [0:STAGES-1];
  logic              nx_c [0:STAGES-1];
  logic              nx_z [0:STAGES-1];

  logic [W-1:0]      sl_sum  [0:STAGES-1];
  logic              sl_cout [0:STAGES-1];
  logic              sl_cmsb [0:STAGES-1];

  // ready[k]: stage k may load this cycle. ready[STAGES+1] is the consumer.
  logic [STAGES+1:1] ready;

  // ---------------------------------------------------------------------
  // Input decode: subtract becomes A + ~B + c0.
  // ---------------------------------------------------------------------
  op_e          op;
  logic [N-1:0] eff_b;
  logic         c0;

  assign op    = op_e'(in_op);
  assign eff_b = op_invert_b(op) ? ~in_b : in_b;
  assign c0    = op_carry_in(op, in_cin);

  // ---------------------------------------------------------------------
  // Per-stage slice datapath.
  // ---------------------------------------------------------------------
  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    localparam logic [N-1:0] ONE  = 1;
    localparam logic [N-1:0] MASK = ((ONE << W) - ONE) << (g * W);

    if (g == 0) begin : g_src_port
      assign src_a[g] = in_a;
      assign src_b[g] = eff_b;
      assign src_s[g] = '0;
      assign src_c[g] = c0;
      assign src_z[g] = 1'b1;
      assign src_v[g] = in_valid;
    end else begin : g_src_reg
      assign src_a[g] = a_q[g];
      assign src_b[g] = b_q[g];
      assign src_s[g] = s_q[g];
      assign src_c[g] = c_q[g];
      assign src_z[g] = z_q[g];
      assign src_v[g] = valid_q[g];
    end

    add_slice #(
      .W (W)
    ) u_slice (
      .a_i    (src_a[g][g*W +: W]),
      .b_i    (src_b[g][g*W +: W]),
      .cin_i  (src_c[g]),
      .sum_o  (sl_sum[g]),
      .cout_o (sl_cout[g]),
      .cmsb_o (sl_cmsb[g])
    );

    // Retire the consumed operand slice; deposit the new result slice
    // (its position in src_s is still zero).
    assign nx_a[g] = src_a[g] & ~MASK;
    assign nx_b[g] = src_b[g] & ~MASK;
    assign nx_s[g] = src_s[g] | (N'(sl_sum[g]) << (g * W));
    assign nx_c[g] = sl_cout[g];
    assign nx_z[g] = src_z[g] & (sl_sum[g] == '0);
  end

  // ---------------------------------------------------------------------
  // Ready chain: a stage may load when it is empty or its contents move
  // on this cycle. Depends only on registered valid bits and out_ready.
  // ---------------------------------------------------------------------
  always_comb begin
    ready = '0;
    ready[STAGES+1] = out_ready;
    for (int k = STAGES; k >= 1; k--) begin
      ready[k] = ~valid_q[k] | ready[k+1];
    end
  end

  assign in_ready = ready[1];

  // ---------------------------------------------------------------------
  // Stage registers. Valid follows the predecessor whenever the stage
  // advances; data loads only when a real beat moves in, so an emptied
  // stage keeps its last data (harmless, valid=0).
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      c_q     <= '0;
      z_q     <= '0;
      v_q     <= 1'b0;
      for (int k = 1; k <= STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 1; k <= STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= src_v[k-1];
          if (src_v[k-1]) begin
            a_q[k] <= nx_a[k-1];
            b_q[k] <= nx_b[k-1];
            s_q[k] <= nx_s[k-1];
            c_q[k] <= nx_c[k-1];
            z_q[k] <= nx_z[k-1];
          end
        end
      end
      // Signed overflow: carry into the MSB differs from carry out of it.
      if (ready[STAGES] && src_v[STAGES-1]) begin
        v_q <= sl_cmsb[STAGES-1] ^ sl_cout[STAGES-1];
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs come straight from the final stage register.
  // ---------------------------------------------------------------------
  assign out_valid = valid_q[STAGES];
  assign out_sum   = s_q[STAGES];
  assign out_c     = c_q[STAGES];
  assign out_v     = v_q;
  assign out_z     = z_q[STAGES];
  assign out_n     = s_q[STAGES][N-1];

endmodule : pipe_add_sub

// File: tb/tb_pipe_add_sub.sv
// tb_pipe_add_sub: directed and streamed checks of pipe_add_sub, N=8, STAGES=2.
module tb_pipe_add_sub;
  import alu_pkg::*;

  localparam int N  = 8;
  localparam int S  = 2;
  localparam int EW = N + 4;

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------
  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_a;
  logic [N-1:0] in_b;
  logic         in_cin;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_sum;
  logic         out_c;
  logic         out_v;
  logic         out_z;
  logic         out_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  pipe_add_sub #(
    .N      (N),
    .STAGES (S)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_cin    (in_cin),
    .in_op     (in_op),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_c     (out_c),
    .out_v     (out_v),
    .out_z     (out_z),
    .out_n     (out_n)
  );

  // ---------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------
  int total = 0;
  int bad   = 0;
  logic [EW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Reference model: {c, v, z, n, sum}. Overflow from operand/result signs.
  function automatic logic [EW-1:0] model(input logic [1:0] op, input logic [N-1:0] a,
                                          input logic [N-1:0] b, input logic cin);
    logic [N-1:0] eb;
    logic         cc;
    logic [N:0]   full;
    logic         v;
    eb   = op[1] ? ~b : b;
    cc   = (op == 2'd0) ? 1'b0 : (op == 2'd2) ? 1'b1 : cin;
    full = {1'b0, a} + {1'b0, eb} + {{N{1'b0}}, cc};
    v    = (a[N-1] == eb[N-1]) && (full[N-1] != a[N-1]);
    return {full[N], v, (full[N-1:0] == '0), full[N-1], full[N-1:0]};
  endfunction

  function automatic logic [EW-1:0] observed();
    return {out_c, out_v, out_z, out_n, out_sum};
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------
  // One isolated beat; checks the latency and the hand-computed result.
  task automatic send_one(input string tag, input logic [1:0] op, input logic [N-1:0] a,
                          input logic [N-1:0] b, input logic cin,
                          input logic [N-1:0] exp_sum, input logic [3:0] exp_flags);
    @(negedge clk);
    in_valid  = 1'b1;
    in_op     = op;
    in_a      = a;
    in_b      = b;
    in_cin    = cin;
    out_ready = 1'b1;
    #1;
    check({tag, "_in_ready"}, in_ready, 1'b1);
    @(negedge clk);
    in_valid = 1'b0;
    in_a     = '1;
    in_b     = '1;
    #1;
    check({tag, "_not_early"}, out_valid, 1'b0);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, out_valid, 1'b1);
    check({tag, "_sum"}, out_sum, exp_sum);
    check({tag, "_flags"}, {out_c, out_v, out_z, out_n}, exp_flags);
    @(negedge clk);
    #1;
    check({tag, "_drained"}, out_valid, 1'b0);
  endtask

  // mode 0: A=B=i ADD, out_ready low on cycles 2..5
  // mode 1: random ops, out_ready=1, in_valid=1 throughout
  // mode 2: random ops, random out_ready
  task automatic run_stream(input string tag, input int nbeats, input int mode);
    int   sent;
    int   got;
    int   cyc;
    int   occ;
    int   bubbles;
    int   stalls;
    logic acc;
    logic emt;
    sent = 0; got = 0; cyc = 0; occ = 0; bubbles = 0; stalls = 0;
    while ((got < nbeats) && (cyc < nbeats * 4 + 50)) begin
      @(negedge clk);
      case (mode)
        0:       out_ready = !((cyc >= 2) && (cyc <= 5));
        1:       out_ready = 1'b1;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (sent < nbeats) begin
        in_valid = 1'b1;
        if (mode == 0) begin
          in_op  = 2'd0;
          in_a   = 8'(sent);
          in_b   = 8'(sent);
          in_cin = 1'b1;
        end else begin
          in_op  = 2'($urandom_range(0, 3));
          in_a   = 8'($urandom_range(0, 255));
          in_b   = 8'($urandom_range(0, 255));
          in_cin = 1'($urandom_range(0, 1));
        end
      end else begin
        in_valid = 1'b0;
      end
      #1;
      // With bubble collapse the unit can accept whenever some stage is
      // empty or the output drains this cycle.
      check({tag, "_in_ready"}, in_ready, (occ < S) || out_ready);
      if (!in_ready) stalls++;
      acc = in_valid && in_ready;
      emt = out_valid && out_ready;
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          check({tag, "_spurious"}, out_valid, 1'b0);
        end else begin
          check({tag, "_result"}, observed(), exp_q[0]);
          if (emt) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end else if (got > 0 && got < nbeats) begin
        bubbles++;
      end
      if (acc) begin
        exp_q.push_back(model(in_op, in_a, in_b, in_cin));
        sent++;
      end
      occ = occ + int'(acc) - int'(emt);
      cyc++;
    end
    in_valid = 1'b0;
    check({tag, "_count"}, got, nbeats);
    check({tag, "_queue_empty"}, exp_q.size(), 0);
    if (mode == 0) check({tag, "_saw_stall"}, (stalls > 0), 1'b1);
    if (mode == 1) check({tag, "_full_rate"}, bubbles, 0);
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------
  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_cin    = 1'b0;
    in_op     = 2'd0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_out_sum", out_sum, 8'h00);
    check("reset_flags", {out_c, out_v, out_z, out_n}, 4'b0000);
    check("reset_in_ready", in_ready, 1'b1);

    // flags order {c, v, z, n}
    send_one("add_7f_01",  2'd0, 8'h7F, 8'h01, 1'b0, 8'h80, 4'b0101);
    send_one("sub_00_01",  2'd2, 8'h00, 8'h01, 1'b0, 8'hFF, 4'b0001);
    send_one("sub_80_01",  2'd2, 8'h80, 8'h01, 1'b0, 8'h7F, 4'b1100);
    send_one("sub_55_55",  2'd2, 8'h55, 8'h55, 1'b0, 8'h00, 4'b1010);
    send_one("adc_ff_00",  2'd1, 8'hFF, 8'h00, 1'b1, 8'h00, 4'b1010);
    send_one("sbb_10_01",  2'd3, 8'h10, 8'h01, 1'b0, 8'h0E, 4'b1000);
    send_one("add_cin_ign", 2'd0, 8'h01, 8'h01, 1'b1, 8'h02, 4'b0000);
    send_one("sub_cin_ign", 2'd2, 8'h05, 8'h03, 1'b0, 8'h02, 4'b1000);
    send_one("sbb_borrow", 2'd3, 8'h10, 8'h01, 1'b1, 8'h0F, 4'b1000);

    run_stream("bp", 6, 0);
    run_stream("rand_full", 1000, 1);
    run_stream("rand_bp", 300, 2);

    // Two beats in flight, then an asynchronous reset mid-cycle.
    @(negedge clk);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_op     = 2'd0;
    in_a      = 8'h11;
    in_b      = 8'h22;
    @(negedge clk);
    in_a      = 8'h33;
    @(negedge clk);
    in_valid  = 1'b0;
    #1;
    check("rst_pre_valid", out_valid, 1'b1);
    check("rst_pre_ready", in_ready, 1'b0);
    #2;
    rst = 1'b1;
    #1;
    check("rst_async_valid", out_valid, 1'b0);
    check("rst_async_sum", out_sum, 8'h00);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("rst_release_ready", in_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      #1;
      check("rst_no_stale", out_valid, 1'b0);
    end
    send_one("post_rst_add", 2'd0, 8'h03, 8'h04, 1'b0, 8'h07, 4'b0000);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_pipe_add_sub
